wrap_counter_checker: RTL and testbench
=======================================

# wrap_counter_checker

Passive receive-side checker for the 10-bit wrapping up-counter interface used in the arithmetic cases. The producer's rule is: on reset the count is 0; on each advance it goes to 1 if the count equals the limit, otherwise to count+1; with no advance it holds. This block samples the producer's advance strobe and count every cycle and predicts the next count. It flags prediction or range violations with a sticky fault and counts completed wraps. It sits beside the producer in the test harness and drives no producer inputs.

## Interface
Parameters:
- WIDTH, 10, count width
- LIMIT, 500, wrap limit; legal counts are 0..LIMIT
- WRAP_W, 16, wrap counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- adv  in  1  producer advance strobe, same cycle as cnt_in
- cnt_in  in  WIDTH  producer count, registered at the producer
- clear  in  1  synchronous clear: drops the fault and the wrap count, returns to UNSYNC
- in_sync  out  1  high in TRACK
- fault  out  1  sticky fault flag
- err_code  out  2  0 none, 1 MISMATCH, 2 RANGE
- err_got  out  WIDTH  cnt_in captured at the fault
- err_exp  out  WIDTH  predicted value captured at the fault
- wrap_count  out  WRAP_W  completed wraps, saturating

## Operation
- Prediction: nxt = adv ? ((cnt_in == LIMIT) ? 1 : cnt_in + 1) : cnt_in.
  - Evaluated every cycle and registered into pred_q.
  - All compares are unsigned at WIDTH bits; no wrap-around at 2^WIDTH is ever expected.
- States: UNSYNC, TRACK, FAULT.
- UNSYNC:
  - If cnt_in <= LIMIT: load pred_q and go to TRACK next cycle.
  - Otherwise: stay in UNSYNC and raise no error.
- TRACK, checked in priority order:
  1. cnt_in > LIMIT: go to FAULT with RANGE.
  2. cnt_in != pred_q: go to FAULT with MISMATCH.
  3. Otherwise: reload pred_q.
- Wrap counting: in TRACK, with no error this cycle, adv && cnt_in == LIMIT increments wrap_count.
  - wrap_count saturates at all ones.
- On entry to FAULT: capture err_got = cnt_in and err_exp = pred_q (RANGE captures pred_q too).
- FAULT: holds until clear; the checker ignores adv and cnt_in.
- clear, in any state: fault = 0, err_code = 0, err_got = 0, err_exp = 0, wrap_count = 0, next state UNSYNC.
- rst has priority over clear.

## Timing
- Reset values:
  - state UNSYNC
  - in_sync 0, fault 0, err_code 0
  - err_got 0, err_exp 0
  - wrap_count 0, pred_q 0
- One-cycle prediction latency: the sample at cycle t is checked against cnt_in at cycle t+1.
- Earliest check: the second cycle after rst deasserts (one UNSYNC cycle, then TRACK).
- Fault latency: a bad cnt_in at cycle t gives fault = 1, err_code valid and in_sync = 0 from cycle t+1.
- wrap_count updates in the cycle after the wrapping sample.
- clear and a violation in the same cycle: clear wins and no fault is recorded.
- rst mid-operation: the next cycle shows all reset values, whatever the state was.

## Configuration
- WRAP_CNT_EN defined: wrap_count is implemented as above.
- WRAP_CNT_EN undefined: there is no wrap counter register and wrap_count is tied to 0. All other behaviour is unchanged.

## Structure
- Shared package wrap_chk_pkg holds:
  - the state enum (UNSYNC, TRACK, FAULT)
  - the err_code constants ERR_NONE, ERR_MISMATCH, ERR_RANGE
- Sub-module wrap_predict: combinational next-count function (cnt_in, adv, LIMIT -> nxt). The producer model and the checker share it.

## Test plan
- Producer reset (cnt 0), then adv high for 1002 cycles -> no fault; wrap_count = 2; cnt sequence 0, 1…500, 1…500, 1, 2.
- In TRACK with cnt 37, adv low for 10 cycles and cnt holding at 37 -> no fault; wrap_count unchanged.
- Inject cnt 41 where 40 is expected -> next cycle fault = 1, err_code = 1, err_got = 41, err_exp = 40, in_sync = 0.
- Inject cnt 501 -> err_code = 2 (RANGE beats MISMATCH); sticky through 20 cycles of legal traffic; clear -> UNSYNC, then TRACK two cycles later.
- clear asserted in the same cycle as a mismatch -> no fault and state UNSYNC; separately, rst asserted in FAULT -> all outputs at reset values next cycle.
- Build without WRAP_CNT_EN and rerun the first scenario -> wrap_count stays 0; fault behaviour is identical.

Source files
------------

// File: rtl/wrap_chk_pkg.sv
// ----------------------------------------------------------------------------
// wrap_chk_pkg : shared state and error-code definitions for wrap_counter_checker
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package wrap_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/wrap_predict.sv
// ----------------------------------------------------------------------------
// wrap_predict : next-count function of the wrapping up-counter (0..LIMIT, wraps to 1)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wrap_predict #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 500
) (
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             adv,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_comb begin
    nxt = cnt_in;
    if (adv) begin
      nxt = (cnt_in == LIM) ? WIDTH'(1) : cnt_in + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/wrap_counter_checker.sv
// ----------------------------------------------------------------------------
// wrap_counter_checker : passive predictor/checker for the wrapping up-counter.
// Optional wrap counter enabled by defining WRAP_CNT_EN.   Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wrap_counter_checker
  import wrap_chk_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int LIMIT  = 500,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              clear,
  output logic              in_sync,
  output logic              fault,
  output logic [1:0]        err_code,
  output logic [WIDTH-1:0]  err_got,
  output logic [WIDTH-1:0]  err_exp,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  state_t           state;
  logic [WIDTH-1:0] pred_q;
  logic [WIDTH-1:0] nxt;
  logic             in_range;
  logic             match;

  wrap_predict #(
    .WIDTH (WIDTH),
    .LIMIT (LIMIT)
  ) u_predict (
    .cnt_in (cnt_in),
    .adv    (adv),
    .nxt    (nxt)
  );

  assign in_range = (cnt_in <= LIM);
  assign match    = (cnt_in == pred_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNSYNC;
      in_sync  <= 1'b0;
      fault    <= 1'b0;
      err_code <= ERR_NONE;
      err_got  <= '0;
      err_exp  <= '0;
      pred_q   <= '0;
    end else if (clear) begin
      state    <= UNSYNC;
      in_sync  <= 1'b0;
      fault    <= 1'b0;
      err_code <= ERR_NONE;
      err_got  <= '0;
      err_exp  <= '0;
    end else begin
      case (state)
        UNSYNC: begin
          // Out-of-range samples while unsynchronised are not errors.
          if (in_range) begin
            pred_q  <= nxt;
            state   <= TRACK;
            in_sync <= 1'b1;
          end
        end
        TRACK: begin
          if (!in_range || !match) begin
            state    <= FAULT;
            in_sync  <= 1'b0;
            fault    <= 1'b1;
            err_code <= in_range ? ERR_MISMATCH : ERR_RANGE;
            err_got  <= cnt_in;
            err_exp  <= pred_q;
          end else begin
            pred_q <= nxt;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state   <= UNSYNC;
          in_sync <= 1'b0;
        end
      endcase
    end
  end

`ifdef WRAP_CNT_EN
  logic              wrap_hit;
  logic [WRAP_W-1:0] wrap_q;

  assign wrap_hit = (state == TRACK) && in_range && match && adv && (cnt_in == LIM);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrap_q <= '0;
    end else if (wrap_hit && (wrap_q != {WRAP_W{1'b1}})) begin
      wrap_q <= wrap_q + WRAP_W'(1);
    end
  end

  assign wrap_count = wrap_q;
`else
  assign wrap_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wrap_counter_checker.sv
// ----------------------------------------------------------------------------
// tb_wrap_counter_checker : directed self-checking bench for wrap_counter_checker
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wrap_counter_checker;

  localparam int WIDTH  = 10;
  localparam int LIMIT  = 500;
  localparam int WRAP_W = 16;
`ifdef WRAP_CNT_EN
  localparam int WRAP_EN = 1;
`else
  localparam int WRAP_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              adv;
  logic [WIDTH-1:0]  cnt_in;
  logic              clear;
  logic              in_sync;
  logic              fault;
  logic [1:0]        err_code;
  logic [WIDTH-1:0]  err_got;
  logic [WIDTH-1:0]  err_exp;
  logic [WRAP_W-1:0] wrap_count;

  int checks = 0;
  int errors = 0;

  wrap_counter_checker #(
    .WIDTH  (WIDTH),
    .LIMIT  (LIMIT),
    .WRAP_W (WRAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adv        (adv),
    .cnt_in     (cnt_in),
    .clear      (clear),
    .in_sync    (in_sync),
    .fault      (fault),
    .err_code   (err_code),
    .err_got    (err_got),
    .err_exp    (err_exp),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample, then return 1ns after the edge that consumed it.
  task automatic drive(input logic a, input int c);
    adv    = a;
    cnt_in = WIDTH'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_sync"},  32'(in_sync),    0);
    chk({tag, "_fault"},    32'(fault),      0);
    chk({tag, "_err_code"}, 32'(err_code),   0);
    chk({tag, "_err_got"},  32'(err_got),    0);
    chk({tag, "_err_exp"},  32'(err_exp),    0);
    chk({tag, "_wrap"},     32'(wrap_count), 0);
  endtask

  initial begin
    int cnt;
    bit a;

    rst    = 1'b1;
    clear  = 1'b0;
    adv    = 1'b0;
    cnt_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Scenario 1: 1002 advances from 0 -> two wraps, last sample (cnt 2) holds.
    cnt = 0;
    for (int i = 0; i <= 1002; i++) begin
      a = (i < 1002);
      drive(a, cnt);
      if (i == 0) chk("sync_after_first", 32'(in_sync), 1);
      if (i == 500) chk("wrap_first", 32'(wrap_count), 32'(WRAP_EN));
      if (a) cnt = (cnt == LIMIT) ? 1 : cnt + 1;
    end
    chk("run_fault", 32'(fault), 0);
    chk("run_in_sync", 32'(in_sync), 1);
    chk("run_wrap", 32'(wrap_count), 32'(2 * WRAP_EN));

    // Scenario 2: climb to 37 and hold for 10 cycles.
    for (int c = 2; c < 37; c++) drive(1'b1, c);
    for (int i = 0; i < 10; i++) drive(1'b0, 37);
    chk("hold_fault", 32'(fault), 0);
    chk("hold_in_sync", 32'(in_sync), 1);
    chk("hold_wrap", 32'(wrap_count), 32'(2 * WRAP_EN));

    // Scenario 3: 41 where 40 is predicted.
    drive(1'b1, 37);
    drive(1'b1, 38);
    drive(1'b1, 39);
    chk("pre_mm_fault", 32'(fault), 0);
    drive(1'b1, 41);
    chk("mm_fault", 32'(fault), 1);
    chk("mm_code", 32'(err_code), 1);
    chk("mm_got", 32'(err_got), 41);
    chk("mm_exp", 32'(err_exp), 40);
    chk("mm_in_sync", 32'(in_sync), 0);

    // Scenario 4: clear, resync at 10, then out-of-range 501.
    clear = 1'b1;
    drive(1'b0, 0);
    clear = 1'b0;
    chk_reset_vals("clear1");
    drive(1'b1, 10);
    chk("resync", 32'(in_sync), 1);
    drive(1'b1, 501);
    chk("rng_fault", 32'(fault), 1);
    chk("rng_code", 32'(err_code), 2);
    chk("rng_got", 32'(err_got), 501);
    chk("rng_exp", 32'(err_exp), 11);
    for (int c = 1; c <= 20; c++) drive(1'b1, c);
    chk("sticky_fault", 32'(fault), 1);
    chk("sticky_code", 32'(err_code), 2);
    chk("sticky_got", 32'(err_got), 501);
    chk("sticky_in_sync", 32'(in_sync), 0);
    clear = 1'b1;
    drive(1'b0, 5);
    clear = 1'b0;
    chk("clr2_in_sync", 32'(in_sync), 0);
    chk("clr2_fault", 32'(fault), 0);
    chk("clr2_code", 32'(err_code), 0);
    drive(1'b0, 600);
    chk("unsync_oor_in_sync", 32'(in_sync), 0);
    chk("unsync_oor_fault", 32'(fault), 0);
    drive(1'b0, 5);
    chk("clr2_track", 32'(in_sync), 1);

    // Scenario 5a: clear in the same cycle as a mismatch (predicted 5, sent 9).
    clear = 1'b1;
    drive(1'b0, 9);
    clear = 1'b0;
    chk("clrmm_fault", 32'(fault), 0);
    chk("clrmm_code", 32'(err_code), 0);
    chk("clrmm_in_sync", 32'(in_sync), 0);

    // Scenario 5b: reach FAULT, then reset.
    drive(1'b0, 7);
    chk("b_track", 32'(in_sync), 1);
    drive(1'b0, 8);
    chk("b_fault", 32'(fault), 1);
    chk("b_got", 32'(err_got), 8);
    chk("b_exp", 32'(err_exp), 7);
    rst = 1'b1;
    clear = 1'b1;
    drive(1'b1, 3);
    rst = 1'b0;
    clear = 1'b0;
    chk_reset_vals("rst_mid");
    drive(1'b0, 4);
    chk("post_rst_track", 32'(in_sync), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
